tas_tx: RTL and testbench



---
 rtl/tas_pkg.sv | 21 ++
 rtl/tas_shift_out.sv | 98 +++++++++
 rtl/tas_tx.sv | 136 +++++++++++++
 tb/tb_tas_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tas_pkg.sv
// rtl/tas_pkg.sv - shared types and constants for the temperature serial link
// Purpose: state encoding and link constants used by both the transmitter
//          and the averaging receiver.
// Contents:
//   tas_tx_state_t : transmitter FSM states
//   TAS_HEADER     : header byte leading every packet
//   TAS_BYTE_W     : width of one serial byte
package tas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    DATA,
    GAP
  } tas_tx_state_t;

  localparam logic [7:0] TAS_HEADER = 8'hA5;
  localparam int         TAS_BYTE_W = 8;

endpackage

// File: rtl/tas_shift_out.sv
// rtl/tas_shift_out.sv - MSB-first parallel-load shift register with bit counter
// Purpose: holds the byte on the wire; bit_o is the registered MSB, so the
//          serial line has no combinational path from any input.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture data_i (takes priority over shift_i)
//   data_i       : byte to send
//   shift_i      : advance one bit (asserted on every enabled cycle)
//   bit_o        : current serial bit
//   done_o       : current cycle carries the last enabled bit of the byte
// Option: TAS_TX_PARITY_EN appends an even-parity bit after bit 0.
module tas_shift_out
  import tas_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [TAS_BYTE_W-1:0] data_i,
  input  logic                  shift_i,
  output logic                  bit_o,
  output logic                  done_o
);

  logic [TAS_BYTE_W-1:0] sr_q, sr_d;
  logic [2:0]            cnt_q, cnt_d;

`ifdef TAS_TX_PARITY_EN
  logic par_q, par_d;
  logic par_phase_q, par_phase_d;

  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    par_phase_d = par_phase_q;
    if (load_i) begin
      sr_d        = data_i;
      cnt_d       = 3'd0;
      par_d       = ^data_i;
      par_phase_d = 1'b0;
    end else if (shift_i) begin
      if (par_phase_q) begin
        // parity cycle ends the byte; zeros already fill the register
        sr_d        = {sr_q[TAS_BYTE_W-2:0], 1'b0};
        par_phase_d = 1'b0;
      end else if (cnt_q == 3'd7) begin
        // after bit 0 the parity bit takes the MSB slot for one cycle
        sr_d        = {par_q, {(TAS_BYTE_W-1){1'b0}}};
        cnt_d       = 3'd0;
        par_phase_d = 1'b1;
      end else begin
        sr_d  = {sr_q[TAS_BYTE_W-2:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_q       <= 1'b0;
      par_phase_q <= 1'b0;
    end else begin
      par_q       <= par_d;
      par_phase_q <= par_phase_d;
    end
  end

  assign done_o = par_phase_q;
`else
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = 3'd0;
    end else if (shift_i) begin
      // zeros shift in so the line idles low once the byte is out
      sr_d  = {sr_q[TAS_BYTE_W-2:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
    end
  end

  assign done_o = (cnt_q == 3'd7);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= 3'd0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_o = sr_q[TAS_BYTE_W-1];

endmodule

// File: rtl/tas_tx.sv
// rtl/tas_tx.sv - temperature serial link packet transmitter
// Purpose: accepts bytes over valid/ready, frames PKT_BYTES bytes behind a
//          header and shifts them out MSB-first with GAP idle cycles between.
// Ports:
//   clk_50, reset          : clock, asynchronous active-high reset
//   in_data, in_valid      : producer byte and qualifier
//   in_ready               : registered, high only in LOAD
//   serial_data, data_ena  : registered serial bit and its enable
//   busy                   : packet in progress
//   pkt_done               : one-cycle pulse after the last gap of a packet
// Option: TAS_TX_PARITY_EN (handled inside tas_shift_out).
module tas_tx #(
  parameter int         PKT_BYTES = 4,
  parameter int         GAP       = 2,
  parameter logic [7:0] HEADER    = tas_pkg::TAS_HEADER
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       serial_data,
  output logic       data_ena,
  output logic       busy,
  output logic       pkt_done
);

  import tas_pkg::*;

  tas_tx_state_t state_q, state_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          data_ena_q, data_ena_d;
  logic          busy_q, busy_d;
  logic          pkt_done_q, pkt_done_d;
  logic          sh_load;
  logic [7:0]    sh_data;
  logic          sh_done;

  tas_shift_out u_shift (
    .clk_i  (clk_50),
    .rst_i  (reset),
    .load_i (sh_load),
    .data_i (sh_data),
    .shift_i(data_ena_q),
    .bit_o  (serial_data),
    .done_o (sh_done)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    busy_d     = busy_q;
    pkt_done_d = 1'b0;
    sh_load    = 1'b0;
    sh_data    = in_data;
    case (state_q)
      IDLE: begin
        // the pkt_done cycle is not a start opportunity, which puts the
        // next header two cycles after pkt_done
        if (in_valid && !pkt_done_q) begin
          state_d    = HDR;
          sh_load    = 1'b1;
          sh_data    = HEADER;
          busy_d     = 1'b1;
          byte_cnt_d = 4'd0;
        end
      end
      HDR: begin
        if (sh_done) begin
          state_d    = tas_pkg::GAP;
          gap_cnt_d  = 4'd0;
          byte_cnt_d = 4'd0;
        end
      end
      tas_pkg::GAP: begin
        if (gap_cnt_q == 4'(GAP - 1)) begin
          if (byte_cnt_q < 4'(PKT_BYTES)) begin
            state_d = LOAD;
          end else begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
            busy_d     = 1'b0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      LOAD: begin
        if (in_valid) begin
          state_d    = DATA;
          sh_load    = 1'b1;
          byte_cnt_d = (byte_cnt_q == 4'(PKT_BYTES)) ? byte_cnt_q : byte_cnt_q + 4'd1;
        end
      end
      DATA: begin
        if (sh_done) begin
          state_d   = tas_pkg::GAP;
          gap_cnt_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    data_ena_d = (state_d == HDR) || (state_d == DATA);
    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= 4'd0;
      gap_cnt_q  <= 4'd0;
      in_ready_q <= 1'b0;
      data_ena_q <= 1'b0;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      in_ready_q <= in_ready_d;
      data_ena_q <= data_ena_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign data_ena = data_ena_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_tas_tx.sv
// tb/tb_tas_tx.sv - scoreboard bench for tas_tx
module tb_tas_tx;

  localparam int PKT  = 4;
  localparam int GAPC = 2;
`ifdef TAS_TX_PARITY_EN
  localparam int BW = 9;
`else
  localparam int BW = 8;
`endif

  logic       clk_50   = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, serial_data, data_ena, busy, pkt_done;

  tas_tx #(.PKT_BYTES(PKT), .GAP(GAPC), .HEADER(8'hA5)) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .serial_data(serial_data),
    .data_ena   (data_ena),
    .busy       (busy),
    .pkt_done   (pkt_done)
  );

  always #10 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;
  int done_cnt = 0;
  int pkts_exp = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [8:0] sh = '0;
  logic [7:0] got_b, exp_b;
  int  nb = 0;
  int  last_bit_cyc = -100;
  int  hs_cnt = 0;
  int  bytes_in_pkt = 0;
  bit  prev_hs = 0, prev_ena = 0, prev_rdy = 0;
  bit  wait_start = 1;
  int  start_from = 0;
  int  exp_rise = -1;

  always @(negedge clk_50) begin
    if (reset) begin
      check("rst_data_ena", data_ena, 0);
      check("rst_busy", busy, 0);
      check("rst_pkt_done", pkt_done, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_serial", serial_data, 0);
      nb = 0; hs_cnt = 0; bytes_in_pkt = 0;
      prev_hs = 0; prev_ena = 0; prev_rdy = 0;
      wait_start = 1; start_from = cyc + 1; exp_rise = -1;
    end else begin
      if (data_ena && !prev_ena) begin
        if (bytes_in_pkt == 0) check("hdr_start_cycle", cyc, exp_rise);
        else                   check("byte_after_handshake", prev_hs, 1);
      end
      if (prev_hs) check("msb_after_handshake", int'(data_ena && !prev_ena && nb == 0), 1);
      if (!data_ena) check("idle_serial_zero", serial_data, 0);
      check("ready_only_in_load", int'(in_ready && (data_ena || !busy)), 0);
      if (data_ena) check("busy_while_sending", busy, 1);
      if (in_ready && !prev_rdy) check("ready_after_gap", cyc, last_bit_cyc + GAPC + 1);

      if (wait_start && cyc >= start_from && in_valid) begin
        exp_rise   = cyc + 1;
        wait_start = 0;
      end

      if (data_ena) begin
        sh = {sh[7:0], serial_data};
        nb++;
        if (nb == BW) begin
`ifdef TAS_TX_PARITY_EN
          got_b = sh[8:1];
          check("parity_bit", sh[0], ^sh[8:1]);
`else
          got_b = sh[7:0];
`endif
          if (exp_q.size() == 0) begin
            check("unexpected_byte", got_b, -1);
          end else begin
            exp_b = exp_q.pop_front();
            check("byte_value", got_b, exp_b);
          end
          nb = 0;
          last_bit_cyc = cyc;
          bytes_in_pkt++;
        end
      end

      if (in_valid && in_ready) hs_cnt++;

      if (pkt_done) begin
        check("done_timing", cyc, last_bit_cyc + GAPC + 1);
        check("handshakes_per_pkt", hs_cnt, PKT);
        check("bytes_per_pkt", bytes_in_pkt, PKT + 1);
        check("busy_low_at_done", busy, 0);
        done_cnt++;
        hs_cnt = 0; bytes_in_pkt = 0;
        wait_start = 1; start_from = cyc + 1; exp_rise = -1;
      end

      prev_hs  = in_valid && in_ready;
      prev_ena = data_ena;
      prev_rdy = in_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk_50);
      if (in_ready) break;
      n++;
      if (n > 400) begin
        check("ready_timeout", 1, 0);
        break;
      end
    end
    tick();
  endtask

  task automatic send_pkt(input logic [7:0] d[PKT], input int stall_idx,
                          input int stall_len, input bit keep);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < PKT; i++) exp_q.push_back(d[i]);
    pkts_exp++;
    for (int i = 0; i < PKT; i++) begin
      if (i == stall_idx && stall_len > 0) begin
        in_valid = 1'b0;
        repeat (stall_len) tick();
      end
      push_byte(d[i]);
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt != pkts_exp && n < 2000) begin
      tick();
      n++;
    end
    if (done_cnt != pkts_exp) check("pkt_done_timeout", done_cnt, pkts_exp);
  endtask

  logic [7:0] d[PKT];
  logic [7:0] d2[PKT];

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // single packet, continuous valid
    d = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_pkt(d, -1, 0, 0);
    wait_done();

    // 20-cycle stall before the third byte
    send_pkt(d, 2, 20, 0);
    wait_done();

    // back-to-back packets
    d2 = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_pkt(d, -1, 0, 1);
    send_pkt(d2, -1, 0, 0);
    wait_done();

    // reset during bit 4 of 0x34 (handshake cycle t, bit 4 at t+4)
    exp_q.push_back(8'hA5);
    for (int i = 0; i < PKT; i++) exp_q.push_back(d[i]);
    push_byte(8'h12);
    push_byte(8'h34);
    in_data = 8'h56;
    repeat (3) tick();
    reset    = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // clean restart; 0x07 and 0xA5 exercise the parity bit
    d = '{8'h07, 8'hA5, 8'hFF, 8'h00};
    send_pkt(d, -1, 0, 0);
    wait_done();

    // randomized packets, stalls and back-to-back chaining
    for (int p = 0; p < 8; p++) begin
      int sidx;
      for (int i = 0; i < PKT; i++) d[i] = 8'($urandom);
      sidx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, PKT - 1)) : -1;
      send_pkt(d, sidx, int'($urandom_range(1, 8)), (p != 7) && ($urandom_range(0, 1) == 1));
    end
    in_valid = 1'b0;
    wait_done();
    repeat (10) tick();

    check("exp_queue_empty", exp_q.size(), 0);
    check("pkt_done_count", done_cnt, pkts_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
